// File: rtl/soft_max_pkg.sv
// Shared network constants for the output-classification stage, plus
// helpers that size the argmax compare tree at elaboration time.
`ifndef SOFTMAX_IN_BIT_WIDTH
`define SOFTMAX_IN_BIT_WIDTH 4
`endif

package soft_max_pkg;

  localparam int SOFTMAX_IN_W      = `SOFTMAX_IN_BIT_WIDTH;
  localparam int SOFTMAX_N_CLASSES = 10;
  localparam int SOFTMAX_IDX_W     = 4;
  localparam int SOFTMAX_MAX_CLASS = 1 << SOFTMAX_IDX_W;

  typedef logic [SOFTMAX_IDX_W-1:0] class_idx_t;

  // Number of nodes present at tree level lvl (level 0 = leaves).
  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Position of the first node of level lvl in the flat node array.
  function automatic int level_offset(input int n, input int lvl);
    int s;
    s = 0;
    for (int k = 0; k < lvl; k++) s += level_count(n, k);
    return s;
  endfunction

  // Compare levels needed to reduce n lanes to one.
  function automatic int tree_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Total nodes across all levels, leaves included.
  function automatic int tree_nodes(input int n);
    return level_offset(n, tree_levels(n) + 1);
  endfunction

endpackage

// File: rtl/soft_max_argmax_node.sv
// One compare node of the argmax tree. Operand a always covers lower class
// indices than operand b, so a wins ties and b wins only when strictly greater.
module argmax_node
  import soft_max_pkg::*;
#(
  parameter int IN_WIDTH = SOFTMAX_IN_W
) (
  input  logic [IN_WIDTH-1:0] a_val,
  input  class_idx_t          a_idx,
  input  logic [IN_WIDTH-1:0] b_val,
  input  class_idx_t          b_idx,
  output logic [IN_WIDTH-1:0] max_val,
  output class_idx_t          max_idx
);

  // Select the winning (value, index) pair, lower index on a tie.
  always_comb begin
    max_val = a_val;
    max_idx = a_idx;
    if (b_val > a_val) begin
      max_val = b_val;
      max_idx = b_idx;
    end
  end

endmodule

// File: rtl/soft_max.sv
// Hard argmax over the per-class output sums: a combinational compare tree of
// argmax_node instances followed by a single registered index output.
`ifndef SOFTMAX_IN_BIT_WIDTH
`define SOFTMAX_IN_BIT_WIDTH 4
`endif

module soft_max
  import soft_max_pkg::*;
#(
  parameter int N_CLASSES = SOFTMAX_N_CLASSES,
  parameter int IN_WIDTH  = `SOFTMAX_IN_BIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CLASSES*IN_WIDTH-1:0] sumIn,
  output logic [3:0]                    result
);

  localparam int LEVELS = tree_levels(N_CLASSES);
  localparam int TOTAL  = tree_nodes(N_CLASSES);
  localparam int ROOT   = TOTAL - 1;

  // Flat node storage: level 0 leaves first, then each reduced level, root last.
  logic [IN_WIDTH-1:0] node_val [TOTAL];
  class_idx_t          node_idx [TOTAL];
  class_idx_t          result_p1;

  // ---- stage p0: leaves straight from the input lanes ----
  for (genvar i = 0; i < N_CLASSES; i++) begin : g_leaf
    assign node_val[i] = sumIn[i*IN_WIDTH +: IN_WIDTH];
    assign node_idx[i] = class_idx_t'(i);
  end

  // Reduce adjacent pairs level by level; an odd node out is forwarded as-is.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_level
    for (genvar j = 0; j < level_count(N_CLASSES, l); j++) begin : g_node
      localparam int SRC = level_offset(N_CLASSES, l - 1) + 2 * j;
      localparam int DST = level_offset(N_CLASSES, l) + j;
      if (2 * j + 1 < level_count(N_CLASSES, l - 1)) begin : g_pair
        argmax_node #(
          .IN_WIDTH (IN_WIDTH)
        ) u_node (
          .a_val   (node_val[SRC]),
          .a_idx   (node_idx[SRC]),
          .b_val   (node_val[SRC+1]),
          .b_idx   (node_idx[SRC+1]),
          .max_val (node_val[DST]),
          .max_idx (node_idx[DST])
        );
      end else begin : g_pass
        assign node_val[DST] = node_val[SRC];
        assign node_idx[DST] = node_idx[SRC];
      end
    end
  end

  // ---- stage p1: register the root index; reset clears it immediately ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) result_p1 <= '0;
    else       result_p1 <= node_idx[ROOT];
  end

  assign result = result_p1;

endmodule

// File: tb/tb_soft_max.sv
// Bench for soft_max: directed vector table, back-to-back latency sequence,
// asynchronous reset sequences and randomized vectors against a linear-scan
// argmax reference.
module tb_soft_max;

  localparam int N  = 10;
  localparam int W  = 4;
  localparam int SW = N * W;

  logic          clk;
  logic          reset;
  logic [SW-1:0] sumIn;
  logic [3:0]    result;

  int checks = 0;
  int errors = 0;

  soft_max dut (
    .clk    (clk),
    .reset  (reset),
    .sumIn  (sumIn),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sum;
    logic [3:0]    exp;
  } vec_t;

  // Reference: first lane holding the largest unsigned value.
  function automatic logic [3:0] ref_argmax(input logic [SW-1:0] v);
    int best;
    best = 0;
    for (int i = 1; i < N; i++)
      if (v[i*W +: W] > v[best*W +: W]) best = i;
    return 4'(best);
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  // Drive a vector on the falling edge, then sample just after the next rising edge.
  task automatic apply(input logic [SW-1:0] v);
    @(negedge clk);
    sumIn = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] rand_vec(input int maxv);
    logic [SW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom_range(maxv, 0));
    return v;
  endfunction

  vec_t tbl [9];
  logic [3:0] prev;

  initial begin
    tbl[0] = '{40'h00_0000_0001, 4'd0};
    tbl[1] = '{40'h12_0000_0000, 4'd8};
    tbl[2] = '{40'h12_43F4_30B8, 4'd5};
    tbl[3] = '{40'h00_0000_0000, 4'd0};
    tbl[4] = '{40'h12_C345_C67B, 4'd3};
    tbl[5] = '{40'hFF_FFFF_FFFF, 4'd0};
    tbl[6] = '{40'hF0_0000_0000, 4'd9};
    tbl[7] = '{40'h00_0000_00F0, 4'd1};
    tbl[8] = '{40'h77_7777_7778, 4'd0};

    // Reset asserted with a nonzero input: output is 0 and stays 0.
    reset = 1'b1;
    sumIn = 40'hF0_0000_0000;
    #1;
    check("reset_immediate", result, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", result, 4'd0);

    // Release: first update on the next rising edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_before_edge", result, 4'd0);
    @(posedge clk);
    #1;
    check("release_first_edge", result, 4'd9);

    // Directed table.
    for (int k = 0; k < 9; k++) begin
      apply(tbl[k].sum);
      check($sformatf("table_%0d", k), result, tbl[k].exp);
      check($sformatf("table_model_%0d", k), result, ref_argmax(tbl[k].sum));
    end

    // Back-to-back: each result lands exactly one edge after its input, and the
    // previous result is still present just before that edge.
    prev = result;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("b2b_hold_%0d", k), result, prev);
      sumIn = tbl[k].sum;
      @(posedge clk);
      #1;
      check($sformatf("b2b_%0d", k), result, tbl[k].exp);
      prev = tbl[k].exp;
    end

    // Reset mid-stream: clears asynchronously, no stale value after release.
    apply(40'h12_0000_0000);
    check("pre_midreset", result, 4'd8);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_async", result, 4'd0);
    @(negedge clk);
    sumIn = 40'h00_0000_F000;
    @(posedge clk);
    #1;
    check("midreset_ignores_input", result, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    sumIn = 40'h00_0000_00F0;
    @(posedge clk);
    #1;
    check("midreset_release", result, 4'd1);

    // Randomized: full range, then a narrow range that forces many ties.
    for (int k = 0; k < 200; k++) begin
      logic [SW-1:0] v;
      v = rand_vec((k < 100) ? 15 : 2);
      apply(v);
      check($sformatf("rand_%0d", k), result, ref_argmax(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soft_max.md
# soft_max

Output-classification stage of the neural-network datapath. Takes the ten per-class output sums from the final layer and reports the index of the largest one, i.e. the hard argmax that stands in for softmax at inference. The block is a pure compare tree followed by one output register. Its single clock and reset are shared with the rest of the network pipeline.

## Interface
Parameters:
- `N_CLASSES`, default 10: number of class sums; `result` width is fixed at 4 bits, so the maximum is 16.
- `IN_WIDTH`, default `` `SOFTMAX_IN_BIT_WIDTH `` (4): width of each class sum.

Ports:
- `clk`, input, 1: single clock; all state is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `sumIn`, input, `N_CLASSES*IN_WIDTH` (40): packed class sums. Lane i occupies bits `[i*IN_WIDTH +: IN_WIDTH]`, so lane 0 is the LSBs.
- `result`, output, 4: registered index (0..N_CLASSES-1) of the maximum lane.

## Operation
- Each lane is an unsigned integer.
- `result` is the index i for which lane i is strictly greatest.
- Ties: the lowest index wins. Compare nodes prefer the lower-index operand unless the higher-index value is strictly greater.
- All-equal input, including all zeros, gives `result = 0`.
- The compare tree is combinational. Each node carries a value and an index.
  - Leaves are the N_CLASSES lanes.
  - Pair adjacent nodes per level: (0,1), (2,3), and so on.
  - An odd node out passes through unchanged.
  - The root index feeds the output register.
- There are no out-of-range results. The index is always < N_CLASSES.
- No handshake. The block samples `sumIn` every cycle, and upstream holds `sumIn` valid for at least one clock edge.

## Timing
- Latency is 1 cycle. `sumIn` stable before rising edge k gives `result` updated right after edge k.
- Throughput is one new input per cycle. Back-to-back changes produce back-to-back results.
- Reset value of `result` is 4'd0.
- `reset` asserted clears `result` immediately, asynchronous to `clk`.
- While `reset` is high, `result` holds 0 and ignores `sumIn`.
- First update is on the first rising edge after `reset` deasserts.
- Reset mid-stream: the in-flight comparison is discarded. No stale value appears after release.
- The combinational path runs from `sumIn` to the register D input: ceil(log2 N_CLASSES) = 4 compare levels.

## Structure
- `` `SOFTMAX_IN_BIT_WIDTH ``, the class count (10) and the index width (4) belong in the shared globals/package next to the other network constants.
- One sub-module, `argmax_node`:
  - inputs: two (value, index) pairs;
  - output: the winning pair under the tie rule above.
- The top level generates the tree of `argmax_node` instances for N_CLASSES and adds the output register.

## Test plan
- Reset: assert `reset` with arbitrary `sumIn` → `result` = 0 immediately and stays 0 across clock edges; release → updates on the next edge.
- Single nonzero lane: `sumIn` = 40'h00_0000_0001 (lane 0 = 1) → `result` = 0 after one edge.
- Upper lanes: `sumIn` = 40'h12_0000_0000 (lane 9 = 1, lane 8 = 2) → `result` = 8.
- Mixed, unsigned check: `sumIn` = 40'h1243_F430_B8, lanes 9..0 = 1,2,4,3,F,4,3,0,B,8 → `result` = 5, because 0xF is the max as unsigned.
- Tie and zero: all zeros → 0; lanes 3 and 7 both = 0xC, all others lower → 3.
- Throughput and latency: a new vector every cycle (the four above back-to-back) → each `result` appears exactly one cycle after its input, with no skipped or duplicated outputs.
